// File: rtl/bist_pkg.sv
// bist_pkg: shared types, widths and golden-model helper for the BIST response checker.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W_DEF = 8;
    localparam int RES_W = 2 * W_DEF + 1;
    localparam int CNT_W = 8;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    function automatic logic [RES_W-1:0] expected(
        input logic [W_DEF-1:0] x1,
        input logic [W_DEF-1:0] x2,
        input logic [W_DEF-1:0] v,
        input logic [W_DEF-1:0] t,
        input logic [W_DEF-1:0] c
    );
        return RES_W'(x1) * RES_W'(x2) + RES_W'(v) * RES_W'(t) + RES_W'(c);
    endfunction

endpackage

// File: rtl/bist_exp_fifo.sv
// bist_exp_fifo: synchronous FIFO holding expected results awaiting comparison.
module bist_exp_fifo #(
    parameter int DW = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bist_response_checker.sv
// bist_response_checker: computes golden x1*x2+v*t+c, queues it and checks returning datapath results.
// Optional: define BIST_RESP_SIGNATURE_EN to add a 16-bit MISR signature output.
module bist_response_checker
    import bist_pkg::*;
#(
    parameter int W = 8,
    parameter int NUM_VECTORS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [W-1:0]        x1,
    input  logic [W-1:0]        x2,
    input  logic [W-1:0]        v,
    input  logic [W-1:0]        t,
    input  logic [W-1:0]        c,
    input  logic                res_valid,
    input  logic [2*W:0]        res_data,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic                proto_err
`ifdef BIST_RESP_SIGNATURE_EN
    ,
    output logic [15:0]         signature
`endif
);

    localparam int RW = 2 * W + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int NW = $clog2(NUM_VECTORS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state, state_nx;
    logic go, accept, push, pop, empty, full;
    logic outstanding, timeout, mm_inc, err_set, fin;
    logic [RW-1:0] head;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0] occ;
    logic s1_v, s2_v;
    logic [2*W-1:0] p_xx, p_vt;
    logic [W-1:0] c_q;
    logic [RW-1:0] sum_q;
    logic [NW-1:0] acc_cnt, chk_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [CNT_W-1:0] mm_nx;

    assign done = state == DONE;

    // Handshake, comparison and next-state decisions
    always_comb begin
        go          = start && (state == IDLE || state == DONE);
        occ         = {1'b0, fifo_cnt} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
        vec_ready   = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH)) && (acc_cnt < NW'(NUM_VECTORS));
        accept      = vec_valid && vec_ready;
        push        = s2_v;
        pop         = (state == RUN) && res_valid && !empty;
        outstanding = acc_cnt > chk_cnt;
        timeout     = (state == RUN) && outstanding && !res_valid && (tmo_cnt == TW'(TIMEOUT - 1));
        mm_inc      = (state == RUN) && res_valid && (empty || head != res_data);
        err_set     = ((state == RUN) && res_valid && empty) || (push && full && !pop)
                      || ((state == DONE) && res_valid) || timeout;
        mm_nx       = (mm_inc && mismatch_cnt != '1) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
        fin         = pop && (chk_cnt == NW'(NUM_VECTORS - 1));
        state_nx    = go ? RUN : ((state == RUN) && (fin || timeout)) ? DONE : state;
    end

    // Run control: state, counters, sticky error and registered verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            chk_cnt      <= '0;
            tmo_cnt      <= '0;
            mismatch_cnt <= '0;
            proto_err    <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                acc_cnt      <= '0;
                chk_cnt      <= '0;
                tmo_cnt      <= '0;
                mismatch_cnt <= '0;
                proto_err    <= 1'b0;
                pass         <= 1'b0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + NW'(1);
                if (pop) chk_cnt <= chk_cnt + NW'(1);
                tmo_cnt      <= (res_valid || !outstanding || state != RUN) ? '0 : tmo_cnt + TW'(1);
                mismatch_cnt <= mm_nx;
                proto_err    <= proto_err || err_set;
                if (fin) pass <= (mm_nx == '0) && !proto_err && !err_set;
                else if (timeout) pass <= 1'b0;
            end
        end
    end

    // Pipeline valid bits; flushed on reset and on run start
    always_ff @(posedge clk) begin
        if (reset || go) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
        end
    end

    // Two-stage golden arithmetic: products first, then the widened sum
    always_ff @(posedge clk) begin
        p_xx  <= {{W{1'b0}}, x1} * {{W{1'b0}}, x2};
        p_vt  <= {{W{1'b0}}, v} * {{W{1'b0}}, t};
        c_q   <= c;
        sum_q <= {1'b0, p_xx} + {1'b0, p_vt} + {{(W+1){1'b0}}, c_q};
    end

    bist_exp_fifo #(
        .DW(RW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset(reset || go),
        .push(push),
        .pop(pop),
        .din(sum_q),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_cnt)
    );

`ifdef BIST_RESP_SIGNATURE_EN
    // MISR over the low result bits of each checked response; holds once the run is done
    always_ff @(posedge clk) begin
        if (reset || go) signature <= '0;
        else if (pop) signature <= {signature[14:0], 1'b0} ^ (signature[15] ? MISR_POLY : 16'h0) ^ res_data[15:0];
    end
`endif

endmodule
